// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite write generator: response codes, FSM state encoding
// and the bit layout of the status word.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t ST_IDLE      = 2'd0;
  localparam wr_state_t ST_ADDR_DATA = 2'd1;
  localparam wr_state_t ST_RESP      = 2'd2;
  localparam wr_state_t ST_DONE      = 2'd3;

  localparam int unsigned STAT_CNT_LSB     = 0;
  localparam int unsigned STAT_ERR_LSB     = 16;
  localparam int unsigned STAT_TIMEOUT_BIT = 24;
  localparam int unsigned STAT_DONE_BIT    = 31;

  function automatic logic [31:0] pack_status(input logic [15:0] cnt, input logic [7:0] err,
                                              input logic timeout, input logic done);
    logic [31:0] s;
    s = 32'h0000_0000;
    s[STAT_CNT_LSB +: 16]  = cnt;
    s[STAT_ERR_LSB +: 8]   = err;
    s[STAT_TIMEOUT_BIT]    = timeout;
    s[STAT_DONE_BIT]       = done;
    return s;
  endfunction

endpackage

// File: rtl/axi_lite_wr_gen_if.sv
// AXI-Lite write channels (AW, W, B) between the write generator and its slave.
interface axi_lite_wr_gen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_axi_lite_ch1_awaddr;
  logic [2:0]          m_axi_lite_ch1_awprot;
  logic                m_axi_lite_ch1_awvalid;
  logic                m_axi_lite_ch1_awready;
  logic [DATA_W-1:0]   m_axi_lite_ch1_wdata;
  logic [DATA_W/8-1:0] m_axi_lite_ch1_wstrb;
  logic                m_axi_lite_ch1_wvalid;
  logic                m_axi_lite_ch1_wready;
  logic [1:0]          m_axi_lite_ch1_bresp;
  logic                m_axi_lite_ch1_bvalid;
  logic                m_axi_lite_ch1_bready;

  modport master (
    output m_axi_lite_ch1_awaddr, m_axi_lite_ch1_awprot, m_axi_lite_ch1_awvalid,
    input  m_axi_lite_ch1_awready,
    output m_axi_lite_ch1_wdata, m_axi_lite_ch1_wstrb, m_axi_lite_ch1_wvalid,
    input  m_axi_lite_ch1_wready,
    input  m_axi_lite_ch1_bresp, m_axi_lite_ch1_bvalid,
    output m_axi_lite_ch1_bready
  );

  modport slave (
    input  m_axi_lite_ch1_awaddr, m_axi_lite_ch1_awprot, m_axi_lite_ch1_awvalid,
    output m_axi_lite_ch1_awready,
    input  m_axi_lite_ch1_wdata, m_axi_lite_ch1_wstrb, m_axi_lite_ch1_wvalid,
    output m_axi_lite_ch1_wready,
    output m_axi_lite_ch1_bresp, m_axi_lite_ch1_bvalid,
    input  m_axi_lite_ch1_bready
  );
endinterface

// File: rtl/axi_lite_wdog.sv
// Cycle watchdog: counts enabled cycles since the last kick and flags the LIMIT-th one.
module axi_lite_wdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (!enable || kick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Expiry fires in the cycle that would bring the count up to LIMIT.
  assign expired = enable && !kick && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axi_lite_wr_gen.sv
// AXI-Lite write generator: issues NUM_WRITES single writes with an address/data ramp.
// Optional watchdog abort is enabled by defining AXI_WR_GEN_TIMEOUT_EN.
module axi_lite_wr_gen
  import axi_lite_pkg::*;
#(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter int unsigned        NUM_WRITES  = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int unsigned        ADDR_STRIDE = 4,
  parameter logic [DATA_W-1:0]  DATA_SEED   = DATA_W'(32'hA5A5_0000),
  parameter int unsigned        TIMEOUT_CYC = 1024
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_areset,
  input  logic               start,
  axi_lite_wr_gen_if.master  m_axi,
  output logic               done,
  output logic [31:0]        status
);
  localparam logic [15:0] LAST_IDX = 16'(NUM_WRITES - 1);

  wr_state_t         state_q, state_d;
  logic [15:0]       idx_q, idx_d, cnt_q, cnt_d;
  logic [7:0]        err_q, err_d;
  logic              timeout_q, timeout_d, done_q, done_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_hs_s, w_hs_s, b_hs_s, expired_s;

  assign aw_hs_s = awvalid_q & m_axi.m_axi_lite_ch1_awready;
  assign w_hs_s  = wvalid_q & m_axi.m_axi_lite_ch1_wready;
  assign b_hs_s  = bready_q & m_axi.m_axi_lite_ch1_bvalid;

`ifdef AXI_WR_GEN_TIMEOUT_EN
  logic wdog_en_s, wdog_kick_s;
  assign wdog_en_s   = (state_q == ST_ADDR_DATA) || (state_q == ST_RESP);
  assign wdog_kick_s = aw_hs_s | w_hs_s | b_hs_s;

  axi_lite_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .enable  (wdog_en_s),
    .kick    (wdog_kick_s),
    .expired (expired_s)
  );
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = ^TIMEOUT_CYC;
  assign expired_s = 1'b0;
`endif

  // Next-state logic; a watchdog expiry overrides every normal transition.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    if (expired_s) begin
      state_d   = ST_DONE;
      timeout_d = 1'b1;
      done_d    = 1'b1;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_ADDR_DATA;
            idx_d     = 16'd0;
            cnt_d     = 16'd0;
            err_d     = 8'd0;
            timeout_d = 1'b0;
            done_d    = 1'b0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = BASE_ADDR;
            wdata_d   = DATA_SEED;
          end else begin
            state_d = state_q;
          end
        end
        ST_ADDR_DATA: begin
          awvalid_d = awvalid_q & ~aw_hs_s;
          wvalid_d  = wvalid_q & ~w_hs_s;
          // A channel whose valid is already low has completed its handshake.
          if ((~awvalid_q | aw_hs_s) & (~wvalid_q | w_hs_s)) begin
            state_d  = ST_RESP;
            bready_d = 1'b1;
          end else begin
            state_d = ST_ADDR_DATA;
          end
        end
        ST_RESP: begin
          if (b_hs_s) begin
            cnt_d    = cnt_q + 16'd1;
            bready_d = 1'b0;
            if ((m_axi.m_axi_lite_ch1_bresp != RESP_OKAY) && (err_q != 8'hFF)) begin
              err_d = err_q + 8'd1;
            end else begin
              err_d = err_q;
            end
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = ST_ADDR_DATA;
              idx_d     = idx_q + 16'd1;
              awaddr_d  = awaddr_q + ADDR_W'(ADDR_STRIDE);
              wdata_d   = wdata_q + DATA_W'(1);
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end
          end else begin
            state_d = ST_RESP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 16'd0;
      cnt_q     <= 16'd0;
      err_q     <= 8'd0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= BASE_ADDR;
      wdata_q   <= DATA_SEED;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign m_axi.m_axi_lite_ch1_awaddr  = awaddr_q;
  assign m_axi.m_axi_lite_ch1_awprot  = 3'b000;
  assign m_axi.m_axi_lite_ch1_awvalid = awvalid_q;
  assign m_axi.m_axi_lite_ch1_wdata   = wdata_q;
  assign m_axi.m_axi_lite_ch1_wstrb   = {(DATA_W/8){1'b1}};
  assign m_axi.m_axi_lite_ch1_wvalid  = wvalid_q;
  assign m_axi.m_axi_lite_ch1_bready  = bready_q;
  assign done   = done_q;
  assign status = pack_status(cnt_q, err_q, timeout_q, done_q);
endmodule

// File: tb/tb_axi_lite_wr_gen.sv
// Bench for axi_lite_wr_gen: two instances (ramp from 0 with 4 writes, wrapping ramp
// with 3 writes), each with a configurable slave and a bus monitor.
module tb_axi_lite_wr_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s [2];
  int         aw_dly [2], w_dly [2], b_dly [2];
  bit         rnd [2], hold [2];
  logic [1:0] bresp_tbl [2][16];
  logic       awv [2], wv [2], brdy [2], dn [2];
  logic [31:0] aa [2], wd [2], st [2];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] base_of(input int g);
    return (g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam logic [31:0] BASE = (g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    localparam int unsigned NW   = (g == 0) ? 4 : 3;

    axi_lite_wr_gen_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_wr_gen #(.NUM_WRITES(NW), .BASE_ADDR(BASE), .TIMEOUT_CYC(8)) dut (
      .s_axi_aclk   (clk),
      .s_axi_areset (rst),
      .start        (start_s[g]),
      .m_axi        (bus),
      .done         (dn[g]),
      .status       (st[g])
    );

    assign awv[g]  = bus.m_axi_lite_ch1_awvalid;
    assign wv[g]   = bus.m_axi_lite_ch1_wvalid;
    assign brdy[g] = bus.m_axi_lite_ch1_bready;
    assign aa[g]   = bus.m_axi_lite_ch1_awaddr;
    assign wd[g]   = bus.m_axi_lite_ch1_wdata;

    int aw_n = 0, w_n = 0, b_n = 0, awhi_n = 0, perr = 0;
    int aw_age = 0, w_age = 0, b_age = 0;
    logic [31:0] aw_log [64];
    logic [31:0] w_log [64];
    logic p_av = 1'b0, p_wv = 1'b0, p_ahs = 1'b0, p_whs = 1'b0;
    logic [31:0] p_aa, p_wd;

    // Monitor: logs handshakes and counts protocol rule violations.
    always @(posedge clk) begin
      if (rst) begin
        aw_n = 0; w_n = 0; b_n = 0; awhi_n = 0;
        p_av = 1'b0; p_wv = 1'b0; p_ahs = 1'b0; p_whs = 1'b0;
      end else begin
        if (p_av && !p_ahs && !dn[g] &&
            (!bus.m_axi_lite_ch1_awvalid || bus.m_axi_lite_ch1_awaddr !== p_aa)) perr++;
        if (p_wv && !p_whs && !dn[g] &&
            (!bus.m_axi_lite_ch1_wvalid || bus.m_axi_lite_ch1_wdata !== p_wd)) perr++;
        if (p_ahs && bus.m_axi_lite_ch1_awvalid) perr++;
        if (p_whs && bus.m_axi_lite_ch1_wvalid) perr++;
        if (bus.m_axi_lite_ch1_bready && !(aw_n == w_n && aw_n == b_n + 1)) perr++;
        if (bus.m_axi_lite_ch1_awvalid) awhi_n++;
        p_av  = bus.m_axi_lite_ch1_awvalid;
        p_wv  = bus.m_axi_lite_ch1_wvalid;
        p_aa  = bus.m_axi_lite_ch1_awaddr;
        p_wd  = bus.m_axi_lite_ch1_wdata;
        p_ahs = bus.m_axi_lite_ch1_awvalid && bus.m_axi_lite_ch1_awready;
        p_whs = bus.m_axi_lite_ch1_wvalid && bus.m_axi_lite_ch1_wready;
        if (p_ahs) begin aw_log[aw_n % 64] = p_aa; aw_n++; end
        if (p_whs) begin w_log[w_n % 64] = p_wd; w_n++; end
        if (bus.m_axi_lite_ch1_bvalid && bus.m_axi_lite_ch1_bready) b_n++;
      end
    end

    // Slave: ready after a programmed delay (or random), response once both beats landed.
    always @(negedge clk) begin
      if (bus.m_axi_lite_ch1_awvalid) begin
        bus.m_axi_lite_ch1_awready = hold[g] ? 1'b0 :
            (rnd[g] ? 1'($urandom_range(0, 1)) : (aw_age >= aw_dly[g]));
        aw_age++;
      end else begin
        bus.m_axi_lite_ch1_awready = 1'b0; aw_age = 0;
      end
      if (bus.m_axi_lite_ch1_wvalid) begin
        bus.m_axi_lite_ch1_wready = hold[g] ? 1'b0 :
            (rnd[g] ? 1'($urandom_range(0, 1)) : (w_age >= w_dly[g]));
        w_age++;
      end else begin
        bus.m_axi_lite_ch1_wready = 1'b0; w_age = 0;
      end
      if (aw_n > b_n && w_n > b_n) begin
        if (bus.m_axi_lite_ch1_bvalid !== 1'b1)
          bus.m_axi_lite_ch1_bvalid = rnd[g] ? 1'($urandom_range(0, 1)) : (b_age >= b_dly[g]);
        bus.m_axi_lite_ch1_bresp = bresp_tbl[g][b_n % 16];
        b_age++;
      end else begin
        bus.m_axi_lite_ch1_bvalid = 1'b0; bus.m_axi_lite_ch1_bresp = 2'b00; b_age = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic start_pulse(input int g);
    @(negedge clk); start_s[g] = 1'b1;
    @(negedge clk); start_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc && !ok; k++) begin
      if (dn[g] === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({awv[g], wv[g], brdy[g], dn[g]} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ctrl[%0d] awv/wv/brdy/done=%b%b%b%b expected 0000",
                 g, awv[g], wv[g], brdy[g], dn[g]);
      end
      checks++;
      if (st[g] !== 32'h0) begin failures++; $display("FAIL reset_status[%0d] got %h expected 0", g, st[g]); end
      checks++;
      if (aa[g] !== base_of(g)) begin failures++; $display("FAIL reset_awaddr[%0d] got %h expected %h", g, aa[g], base_of(g)); end
      checks++;
      if (wd[g] !== 32'hA5A5_0000) begin failures++; $display("FAIL reset_wdata[%0d] got %h expected a5a50000", g, wd[g]); end
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    start_pulse(0);
    wait_done(0, 200, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL basic_done got timeout expected done"); end
    checks++;
    if (gen_dut[0].aw_n !== 4) begin failures++; $display("FAIL basic_count got %0d expected 4", gen_dut[0].aw_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gen_dut[0].aw_log[i] !== 32'(4 * i)) begin
        failures++; $display("FAIL basic_awaddr[%0d] got %h expected %h", i, gen_dut[0].aw_log[i], 32'(4 * i));
      end
      checks++;
      if (gen_dut[0].w_log[i] !== 32'hA5A5_0000 + 32'(i)) begin
        failures++; $display("FAIL basic_wdata[%0d] got %h expected %h", i, gen_dut[0].w_log[i], 32'hA5A5_0000 + 32'(i));
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1 || st[0] !== 32'h8000_0004) begin
      failures++; $display("FAIL basic_status_held done=%b status=%h expected 1/80000004", dn[0], st[0]);
    end
    checks++;
    if ({awv[0], wv[0], brdy[0]} !== 3'b000) begin
      failures++; $display("FAIL basic_idle_bus got %b%b%b expected 000", awv[0], wv[0], brdy[0]);
    end
  endtask

  task automatic test_aw_delay();
    bit ok;
    int w_fall = -1, aw_fall = -1, b_rise = -1, addr_bad = 0;
    do_reset();
    aw_dly[0] = 3;
    start_pulse(0);
    for (int k = 0; k < 20 && b_rise < 0; k++) begin
      if (w_fall < 0 && wv[0] === 1'b0) w_fall = k;
      if (aw_fall < 0 && awv[0] === 1'b0) aw_fall = k;
      if (brdy[0] === 1'b1) b_rise = k;
      if (awv[0] === 1'b1 && aa[0] !== 32'h0) addr_bad++;
      if (b_rise < 0) @(negedge clk);
    end
    checks++;
    if (w_fall != 1 || aw_fall != 4 || b_rise != 4) begin
      failures++; $display("FAIL awdelay_timing w_fall=%0d aw_fall=%0d b_rise=%0d expected 1/4/4", w_fall, aw_fall, b_rise);
    end
    checks++;
    if (addr_bad != 0) begin failures++; $display("FAIL awdelay_addr_stable got %0d bad cycles expected 0", addr_bad); end
    wait_done(0, 400, ok);
    checks++;
    if (ok !== 1'b1 || st[0] !== 32'h8000_0004) begin
      failures++; $display("FAIL awdelay_status ok=%b status=%h expected 1/80000004", ok, st[0]);
    end
    aw_dly[0] = 0;
  endtask

  task automatic test_bresp_err();
    bit ok;
    do_reset();
    bresp_tbl[0][1] = 2'b10;
    bresp_tbl[0][2] = 2'b10;
    start_pulse(0);
    wait_done(0, 200, ok);
    checks++;
    if (ok !== 1'b1 || st[0][23:16] !== 8'd2 || st[0][15:0] !== 16'd4) begin
      failures++; $display("FAIL bresp_err ok=%b status=%h expected errors=2 count=4", ok, st[0]);
    end
    bresp_tbl[0][1] = 2'b00;
    bresp_tbl[0][2] = 2'b00;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int a0, b0, errs;
    logic [31:0] exp_st;
    do_reset();
    rnd[0] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 16; j++) bresp_tbl[0][j] = 2'($urandom_range(0, 3));
      a0 = gen_dut[0].aw_n;
      b0 = gen_dut[0].b_n;
      errs = 0;
      for (int i = 0; i < 4; i++) if (bresp_tbl[0][(b0 + i) % 16] != 2'b00) errs++;
      exp_st = 32'h8000_0000 | (32'(errs) << 16) | 32'd4;
      start_pulse(0);
      wait_done(0, 600, ok);
      checks++;
      if (ok !== 1'b1 || st[0] !== exp_st) begin
        failures++; $display("FAIL b2b_status[%0d] ok=%b got %h expected %h", r, ok, st[0], exp_st);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gen_dut[0].aw_log[(a0 + i) % 64] !== 32'(4 * i) ||
            gen_dut[0].w_log[(a0 + i) % 64] !== 32'hA5A5_0000 + 32'(i)) begin
          failures++; $display("FAIL b2b_beat[%0d.%0d] addr=%h data=%h expected %h/%h", r, i,
                               gen_dut[0].aw_log[(a0 + i) % 64], gen_dut[0].w_log[(a0 + i) % 64],
                               32'(4 * i), 32'hA5A5_0000 + 32'(i));
        end
      end
    end
    rnd[0] = 1'b0;
    for (int j = 0; j < 16; j++) bresp_tbl[0][j] = 2'b00;
  endtask

  task automatic test_addr_wrap();
    bit ok;
    logic [31:0] ea;
    do_reset();
    start_pulse(1);
    wait_done(1, 200, ok);
    checks++;
    if (ok !== 1'b1 || gen_dut[1].aw_n !== 3 || st[1] !== 32'h8000_0003) begin
      failures++; $display("FAIL wrap_run ok=%b writes=%0d status=%h expected 1/3/80000003", ok, gen_dut[1].aw_n, st[1]);
    end
    for (int i = 0; i < 3; i++) begin
      ea = 32'hFFFF_FFF8 + 32'(4 * i);
      checks++;
      if (gen_dut[1].aw_log[i] !== ea) begin
        failures++; $display("FAIL wrap_awaddr[%0d] got %h expected %h", i, gen_dut[1].aw_log[i], ea);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    hold[0] = 1'b1;
    start_pulse(0);
`ifdef AXI_WR_GEN_TIMEOUT_EN
    wait_done(0, 100, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL timeout_abort got no done expected done"); end
    checks++;
    if (gen_dut[0].awhi_n !== 8) begin failures++; $display("FAIL timeout_cycles got %0d expected 8", gen_dut[0].awhi_n); end
    checks++;
    if ({awv[0], wv[0], brdy[0]} !== 3'b000 || st[0] !== 32'h8100_0000) begin
      failures++; $display("FAIL timeout_state bus=%b%b%b status=%h expected 000/81000000", awv[0], wv[0], brdy[0], st[0]);
    end
`else
    ok = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (dn[0] !== 1'b0 || awv[0] !== 1'b1 || wv[0] !== 1'b1 || st[0] !== 32'h0) begin
      failures++; $display("FAIL no_wdog_wait done=%b awv=%b wv=%b status=%h expected 0/1/1/0", dn[0], awv[0], wv[0], st[0]);
    end
`endif
    hold[0] = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    b_dly[0] = 30;
    start_pulse(0);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (brdy[0] === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL mid_reach_resp got no bready expected bready"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({awv[0], wv[0], brdy[0], dn[0]} !== 4'b0000 || st[0] !== 32'h0 ||
        aa[0] !== 32'h0 || wd[0] !== 32'hA5A5_0000) begin
      failures++; $display("FAIL mid_reset_state bus=%b%b%b done=%b status=%h addr=%h data=%h expected reset values",
                           awv[0], wv[0], brdy[0], dn[0], st[0], aa[0], wd[0]);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (gen_dut[0].aw_n !== 0 || awv[0] !== 1'b0) begin
      failures++; $display("FAIL mid_no_retry writes=%0d awv=%b expected 0/0", gen_dut[0].aw_n, awv[0]);
    end
    b_dly[0] = 0;
    start_pulse(0);
    wait_done(0, 200, ok);
    checks++;
    if (ok !== 1'b1 || st[0] !== 32'h8000_0004) begin
      failures++; $display("FAIL mid_rerun ok=%b status=%h expected 1/80000004", ok, st[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      aw_dly[g] = 0; w_dly[g] = 0; b_dly[g] = 0;
      rnd[g] = 1'b0; hold[g] = 1'b0;
      for (int j = 0; j < 16; j++) bresp_tbl[g][j] = 2'b00;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_aw_delay();
    test_bresp_err();
    test_back_to_back();
    test_addr_wrap();
    test_timeout();
    test_reset_mid();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (g == 0 ? gen_dut[0].perr !== 0 : gen_dut[1].perr !== 0) begin
        failures++; $display("FAIL protocol_rules[%0d] got %0d violations expected 0", g,
                             g == 0 ? gen_dut[0].perr : gen_dut[1].perr);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit reached at %0t expected bench to finish earlier", $time);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/axi_lite_wr_gen.md
AXI_LITE_WR_GEN -- requirements
Module: axi_lite_wr_gen

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 32, address width
- DATA_W, 32, data width (32 or 64)
- NUM_WRITES, 16, writes per run (1..65535)
- BASE_ADDR, 0, first address
- ADDR_STRIDE, 4, address increment per write
- DATA_SEED, 32'hA5A5_0000, data of write 0
- TIMEOUT_CYC, 1024, watchdog limit in cycles
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- s_axi_aclk, in, 1, clock
- s_axi_areset, in, 1, synchronous active-high reset
- start, in, 1, run request pulse
- m_axi_lite_ch1_awaddr, out, ADDR_W, write address
- m_axi_lite_ch1_awprot, out, 3, constant 3'b000
- m_axi_lite_ch1_awvalid, out, 1, AW valid
- m_axi_lite_ch1_awready, in, 1, AW ready
- m_axi_lite_ch1_wdata, out, DATA_W, write data
- m_axi_lite_ch1_wstrb, out, DATA_W/8, all ones
- m_axi_lite_ch1_wvalid, out, 1, W valid
- m_axi_lite_ch1_wready, in, 1, W ready
- m_axi_lite_ch1_bresp, in, 2, write response
- m_axi_lite_ch1_bvalid, in, 1, B valid
- m_axi_lite_ch1_bready, out, 1, B ready
- done, out, 1, run complete, held
- status, out, 32, result word

Function
REQ-004 The FSM SHALL have the states IDLE, ADDR_DATA, RESP and DONE, with one write outstanding at a time.
REQ-005 start SHALL be sampled only in IDLE or DONE; on start=1, the block SHALL clear index, counters, done and status, and SHALL enter ADDR_DATA on the next cycle. start in ADDR_DATA or RESP SHALL be ignored.
REQ-006 In ADDR_DATA, awvalid and wvalid SHALL both be high on entry; each SHALL drop the cycle after its own valid&ready handshake, independently of the other.
REQ-007 While awvalid or wvalid is high, awaddr and wdata SHALL be stable; awvalid and wvalid SHALL never depend combinationally on the ready inputs.
REQ-008 When both AW and W have handshaken (in the same cycle or in different cycles), the FSM SHALL go to RESP, and bready SHALL be high only in RESP.
REQ-009 For write i: awaddr = BASE_ADDR + i*ADDR_STRIDE, truncated to ADDR_W and wrapping modulo 2^ADDR_W.
REQ-010 For write i: wdata = DATA_SEED + i, truncated to DATA_W.
REQ-011 On bvalid&bready, the block SHALL increment the completed count. If bresp != 2'b00, it SHALL increment the error count, which saturates at 255.
REQ-012 After the response to write i: if i = NUM_WRITES-1, the FSM SHALL go to DONE; otherwise it SHALL go to ADDR_DATA with i+1, so there is no idle cycle between writes.
REQ-013 In DONE, done SHALL be 1 and SHALL hold until the next start or reset.
REQ-014 The status word SHALL be laid out as:
- [15:0] completed writes
- [23:16] error count
- [24] timeout
- [30:25] 0
- [31] equals done
REQ-015 status SHALL update in the cycle after each response.

Reset
REQ-016 In the cycle after s_axi_areset=1, the block SHALL be in IDLE with awvalid=wvalid=bready=0, done=0, status=0, index=0, awaddr=BASE_ADDR and wdata=DATA_SEED.
REQ-017 On reset mid-transfer, the block SHALL abandon the transfer, drop all valids and bready, and SHALL NOT issue a retry.

Configuration
REQ-018 With AXI_WR_GEN_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in ADDR_DATA or RESP, and SHALL clear on any AW, W or B handshake.
REQ-019 With AXI_WR_GEN_TIMEOUT_EN defined, when the watchdog count reaches TIMEOUT_CYC, the block SHALL:
- set status[24]
- drop awvalid, wvalid and bready
- go to DONE

This abort is a deliberate, test-only protocol exception.
REQ-020 Without AXI_WR_GEN_TIMEOUT_EN, the watchdog SHALL be absent, TIMEOUT_CYC SHALL be unused, status[24] SHALL be 0, and the block SHALL wait indefinitely.

Structure
REQ-021 A shared package axi_lite_pkg SHALL hold:
- the resp typedef (OKAY, EXOKAY, SLVERR, DECERR)
- the FSM state typedef
- the status bit-position constants
REQ-022 The watchdog SHALL be a sub-module, axi_lite_wdog, with inputs clk, rst, enable and kick, and output expired; it SHALL be instantiated only under the macro.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- NUM_WRITES=4, slave always ready, bresp=0 -> four writes with awaddr 0x0, 0x4, 0x8, 0xC and wdata A5A50000..A5A50003; done=1; status=0x8000_0004.
- awready delayed 3 cycles, wready immediate -> wvalid drops first, awvalid holds with stable awaddr until the handshake, and bready rises only after both handshakes.
- bresp=2'b10 on writes 1 and 2 of 4 -> status[23:16]=2, status[15:0]=4.
- BASE_ADDR=0xFFFF_FFF8, NUM_WRITES=3 -> awaddr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Macro defined, TIMEOUT_CYC=8, awready held 0 -> abort after 8 cycles; all valids 0; done=1; status=0x8100_0000.
- Reset asserted while in RESP, then start -> outputs at reset values after one cycle, and a clean rerun yields status=0x8000_0004.
